// File: rtl/rate_tick_pkg.sv
// Shared constants for the rate tick generator: base divisor table, FSM state
// encoding and the scaled divisor lookup used at elaboration time.
package rate_tick_pkg;

  // Base divisors against the 50 MHz system clock
  localparam int unsigned DIV_FAST = 1;
  localparam int unsigned DIV_10HZ = 5_000_000;
  localparam int unsigned DIV_20HZ = 2_500_000;
  localparam int unsigned DIV_40HZ = 1_250_000;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Scaled divisor for a table index; floored and clamped so a period is never zero
  function automatic longint unsigned rate_div(input int unsigned index,
                                               input int unsigned scale);
    longint unsigned base;
    longint unsigned q;
    case (index)
      0:       base = longint'(DIV_FAST);
      1:       base = longint'(DIV_10HZ);
      2:       base = longint'(DIV_20HZ);
      3:       base = longint'(DIV_40HZ);
      default: base = longint'(DIV_FAST);
    endcase
    q = (scale == 0) ? base : base / longint'(scale);
    if (q == 0) q = 1;
    return q;
  endfunction

endpackage

// File: rtl/rate_tick_gen_table.sv
// Combinational select -> divisor lookup. Entries are elaboration-time constants
// (scaled and clamped), so the lookup is a plain mux.
module rate_div_table
  import rate_tick_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned TABLE_SCALE = 1
) (
  input  logic [SEL_W-1:0] select,
  output logic [CNT_W-1:0] div
);

  logic [CNT_W-1:0] div_tbl [2**SEL_W];

  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_tbl
    assign div_tbl[i] = CNT_W'(rate_div(i, TABLE_SCALE));
    // Every entry must be representable by the counter
    if ((rate_div(i, TABLE_SCALE) >> CNT_W) != 0) begin : g_ovf
      $error("rate_div_table: divisor entry does not fit CNT_W");
    end
  end

  // Index the constant table
  always_comb begin
    div = div_tbl[select];
  end

endmodule

// File: rtl/rate_tick_gen.sv
// Rate tick generator: owns the down-counter and FSM, emits a registered one-cycle
// tick at the selected rate. Optional runtime divisor override is compiled in
// with RATE_TICK_OVERRIDE_EN.
module rate_tick_gen
  import rate_tick_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned NUM_RATES   = 4,
  parameter int unsigned TABLE_SCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             oneshot,
  input  logic [SEL_W-1:0] select,
`ifdef RATE_TICK_OVERRIDE_EN
  input  logic             ovr_load,
  input  logic [CNT_W-1:0] ovr_value,
  output logic             ovr_active,
`endif
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             sel_err,
  output logic [CNT_W-1:0] count
);

  if (NUM_RATES > 2**SEL_W) begin : g_bad_num_rates
    $error("rate_tick_gen: NUM_RATES exceeds select range");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             sel_err_q, sel_err_d;

  logic [CNT_W-1:0] tbl_div;
  logic [CNT_W-1:0] load_div;
  logic             reload_req;
  logic             sel_bad;

  rate_div_table #(
    .CNT_W       (CNT_W),
    .SEL_W       (SEL_W),
    .TABLE_SCALE (TABLE_SCALE)
  ) u_table (
    .select (select),
    .div    (tbl_div)
  );

  assign sel_bad = (32'(select) >= NUM_RATES);

`ifdef RATE_TICK_OVERRIDE_EN
  logic [CNT_W-1:0] ovr_div_q, ovr_div_d;
  logic             ovr_active_q, ovr_active_d;
  logic [CNT_W-1:0] ovr_clamped;

  // A zero override would mean a zero-length period; store it as 1
  assign ovr_clamped = (ovr_value == '0) ? CNT_W'(1) : ovr_value;
  // A fresh load takes effect on the same edge it is latched
  assign load_div    = ovr_load ? ovr_clamped : (ovr_active_q ? ovr_div_q : tbl_div);
  assign reload_req  = (select != sel_q) || ovr_load;

  // Override register: sticky until reset
  always_comb begin
    ovr_div_d    = ovr_load ? ovr_clamped : ovr_div_q;
    ovr_active_d = ovr_active_q | ovr_load;
  end

  // Override state register
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_div_q    <= CNT_W'(1);
      ovr_active_q <= 1'b0;
    end else begin
      ovr_div_q    <= ovr_div_d;
      ovr_active_q <= ovr_active_d;
    end
  end

  assign ovr_active = ovr_active_q;
`else
  assign load_div   = tbl_div;
  assign reload_req = (select != sel_q);
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sel_q     <= '0;
      mode_q    <= 1'b0;
      tick_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Next-state and counter logic; RUN checks are in strict priority order
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    tick_d    = 1'b0;
    sel_err_d = sel_bad;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (enable && !sel_bad) begin
          count_d = load_div - CNT_W'(1);
          sel_d   = select;
          mode_d  = oneshot;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable || sel_bad) begin
          state_d = IDLE;
          count_d = '0;
        end else if (reload_req) begin
          // Restart a full period; no tick on the restart edge
          count_d = load_div - CNT_W'(1);
          sel_d   = select;
        end else if (count_q == '0) begin
          tick_d = 1'b1;
          if (mode_q) begin
            state_d = DONE;
            count_d = '0;
          end else begin
            count_d = load_div - CNT_W'(1);
          end
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
        count_d = '0;
        if (!enable) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    tick    = tick_q;
    running = (state_q == RUN);
    done    = (state_q == DONE);
    sel_err = sel_err_q;
    count   = count_q;
  end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Scoreboard bench for rate_tick_gen. Stimulus pushes expected tick cycles and
// timed signal expectations; a negedge monitor pops and compares them.
module tb_rate_tick_gen;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned NUM_RATES   = 3;
  localparam int unsigned TABLE_SCALE = 250_000;
  localparam int unsigned MAX_CYC     = 5000;

  localparam int ID_COUNT = 0, ID_RUN = 1, ID_DONE = 2, ID_SERR = 3, ID_TICK = 4, ID_OVR = 5;

  logic             clk = 1'b0;
  logic             reset, enable, oneshot;
  logic [SEL_W-1:0] select;
  logic             tick, running, done, sel_err;
  logic [CNT_W-1:0] count;
`ifdef RATE_TICK_OVERRIDE_EN
  logic             ovr_load;
  logic [CNT_W-1:0] ovr_value;
  logic             ovr_active;
`endif

  rate_tick_gen #(
    .CNT_W       (CNT_W),
    .SEL_W       (SEL_W),
    .NUM_RATES   (NUM_RATES),
    .TABLE_SCALE (TABLE_SCALE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .oneshot    (oneshot),
    .select     (select),
`ifdef RATE_TICK_OVERRIDE_EN
    .ovr_load   (ovr_load),
    .ovr_value  (ovr_value),
    .ovr_active (ovr_active),
`endif
    .tick       (tick),
    .running    (running),
    .done       (done),
    .sel_err    (sel_err),
    .count      (count)
  );

  always #10 clk = ~clk;

  // Edge counter: value n means the n-th rising edge has happened
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int          id;
    logic [31:0] val;
  } chk_t;

  chk_t        chkq[$];
  int unsigned tickq[$];
  bit          stim_done = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic string sig_name(input int id);
    case (id)
      ID_COUNT: return "count";
      ID_RUN:   return "running";
      ID_DONE:  return "done";
      ID_SERR:  return "sel_err";
      ID_TICK:  return "tick";
      default:  return "ovr_active";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int id);
    case (id)
      ID_COUNT: return 32'(count);
      ID_RUN:   return 32'(running);
      ID_DONE:  return 32'(done);
      ID_SERR:  return 32'(sel_err);
      ID_TICK:  return 32'(tick);
`ifdef RATE_TICK_OVERRIDE_EN
      ID_OVR:   return 32'(ovr_active);
`endif
      default:  return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: tick scoreboard, timed expectations, end-of-run flush and summary
  int unsigned exp_cyc;
  logic [31:0] act;
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      n_chk++;
      if (tickq.size() == 0) begin
        n_fail++;
        $display("FAIL tick_time: tick at cycle %0d, required none", cyc);
      end else begin
        exp_cyc = tickq.pop_front();
        if (exp_cyc != cyc) begin
          n_fail++;
          $display("FAIL tick_time: tick at cycle %0d, required cycle %0d", cyc, exp_cyc);
        end
      end
    end else if (tickq.size() != 0 && tickq[0] < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_time: no tick by cycle %0d, required cycle %0d", cyc, tickq[0]);
      void'(tickq.pop_front());
    end
    for (int i = chkq.size() - 1; i >= 0; i--) begin
      if (chkq[i].at <= cyc) begin
        n_chk++;
        act = actual(chkq[i].id);
        if (act !== chkq[i].val) begin
          n_fail++;
          $display("FAIL %s @%0d: got %0d, required %0d", sig_name(chkq[i].id), cyc, act,
                   chkq[i].val);
        end
        chkq.delete(i);
      end
    end
    if (stim_done || cyc > MAX_CYC) begin
      if (!stim_done) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: cycle %0d, required stimulus done", cyc);
      end
      while (tickq.size() != 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tick_time: missing tick, required cycle %0d", tickq.pop_front());
      end
      while (chkq.size() != 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s: not evaluated, required at cycle %0d", sig_name(chkq[0].id),
                 chkq[0].at);
        void'(chkq.pop_front());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  task automatic expect_at(input int unsigned at, input int id, input logic [31:0] val);
    chkq.push_back('{at: at, id: id, val: val});
  endtask

  task automatic wait_to(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  int unsigned c, l, s, l2;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    oneshot = 1'b0;
    select  = '0;
`ifdef RATE_TICK_OVERRIDE_EN
    ovr_load  = 1'b0;
    ovr_value = '0;
`endif
    // Reset values
    @(negedge clk);
    c = cyc;
    expect_at(c + 1, ID_COUNT, 0);
    expect_at(c + 1, ID_RUN, 0);
    expect_at(c + 1, ID_DONE, 0);
    expect_at(c + 1, ID_TICK, 0);
    expect_at(c + 1, ID_SERR, 0);
    wait_to(c + 2);
    reset = 1'b0;

    // Continuous, D=20: ticks at +20, +40, +60
    @(negedge clk);
    c = cyc; select = 2'd1; enable = 1'b1; l = c + 1;
    tickq.push_back(l + 20); tickq.push_back(l + 40); tickq.push_back(l + 60);
    expect_at(l, ID_COUNT, 19);
    expect_at(l, ID_RUN, 1);
    expect_at(l + 19, ID_COUNT, 0);
    expect_at(l + 20, ID_COUNT, 19);
    expect_at(l + 41, ID_COUNT, 18);
    wait_to(l + 61);
    enable = 1'b0;
    expect_at(l + 62, ID_RUN, 0);
    expect_at(l + 62, ID_COUNT, 0);
    wait_to(l + 62);

    // D=1: tick every cycle, one-cycle disable, restart
    c = cyc; select = 2'd0; enable = 1'b1; l = c + 1;
    for (int k = 1; k <= 4; k++) tickq.push_back(l + k);
    expect_at(l + 2, ID_RUN, 1);
    wait_to(l + 4);
    enable = 1'b0;
    expect_at(l + 5, ID_TICK, 0);
    expect_at(l + 5, ID_RUN, 0);
    wait_to(l + 5);
    enable = 1'b1;
    tickq.push_back(l + 7); tickq.push_back(l + 8);
    wait_to(l + 8);
    enable = 1'b0;
    wait_to(l + 9);

    // Select change mid-count: D=10 -> D=20 at count=4
    c = cyc; select = 2'd2; enable = 1'b1; l = c + 1;
    expect_at(l, ID_COUNT, 9);
    expect_at(l + 5, ID_COUNT, 4);
    wait_to(l + 5);
    select = 2'd1; s = l + 6;
    expect_at(s, ID_COUNT, 19);
    expect_at(s, ID_TICK, 0);
    tickq.push_back(s + 20);
    expect_at(s + 20, ID_COUNT, 19);
    wait_to(s + 20);
    enable = 1'b0;
    wait_to(s + 21);

    // One-shot D=10, select change ignored in DONE, re-arm
    c = cyc; select = 2'd2; oneshot = 1'b1; enable = 1'b1; l = c + 1;
    tickq.push_back(l + 10);
    expect_at(l + 10, ID_DONE, 1);
    expect_at(l + 10, ID_RUN, 0);
    expect_at(l + 10, ID_COUNT, 0);
    wait_to(l);
    oneshot = 1'b0;
    wait_to(l + 12);
    select = 2'd1;
    expect_at(l + 14, ID_DONE, 1);
    expect_at(l + 14, ID_COUNT, 0);
    wait_to(l + 15);
    enable = 1'b0;
    expect_at(l + 16, ID_DONE, 0);
    wait_to(l + 16);
    select = 2'd2; oneshot = 1'b1; enable = 1'b1; l2 = l + 17;
    tickq.push_back(l2 + 10);
    expect_at(l2 + 10, ID_DONE, 1);
    wait_to(l2 + 11);
    enable = 1'b0; oneshot = 1'b0;
    wait_to(l2 + 12);

    // Invalid select (NUM_RATES=3): blocks entry, aborts RUN; reset mid-count
    c = cyc; select = 2'd3; enable = 1'b1;
    expect_at(c + 1, ID_SERR, 1);
    expect_at(c + 1, ID_RUN, 0);
    expect_at(c + 2, ID_RUN, 0);
    wait_to(c + 2);
    select = 2'd1; l = c + 3;
    expect_at(l, ID_SERR, 0);
    expect_at(l, ID_RUN, 1);
    wait_to(l + 3);
    select = 2'd3;
    expect_at(l + 4, ID_RUN, 0);
    expect_at(l + 4, ID_SERR, 1);
    expect_at(l + 4, ID_COUNT, 0);
    expect_at(l + 4, ID_TICK, 0);
    wait_to(l + 4);
    select = 2'd1; l2 = l + 5;
    expect_at(l2, ID_RUN, 1);
    expect_at(l2 + 6, ID_COUNT, 13);
    wait_to(l2 + 6);
    reset = 1'b1;
    expect_at(l2 + 7, ID_COUNT, 0);
    expect_at(l2 + 7, ID_RUN, 0);
    expect_at(l2 + 7, ID_DONE, 0);
    expect_at(l2 + 7, ID_TICK, 0);
    expect_at(l2 + 7, ID_SERR, 0);
    wait_to(l2 + 7);
    enable = 1'b0;
    wait_to(l2 + 8);
    reset = 1'b0;

`ifdef RATE_TICK_OVERRIDE_EN
    // Override 3 for any select, then override 0 -> every cycle
    @(negedge clk);
    c = cyc; ovr_load = 1'b1; ovr_value = 3; select = 2'd1;
    expect_at(c + 1, ID_OVR, 1);
    wait_to(c + 1);
    ovr_load = 1'b0; enable = 1'b1;
    tickq.push_back(c + 5); tickq.push_back(c + 8);
    wait_to(c + 8);
    select = 2'd2;
    expect_at(c + 9, ID_TICK, 0);
    tickq.push_back(c + 12);
    wait_to(c + 12);
    ovr_load = 1'b1; ovr_value = 0;
    wait_to(c + 13);
    ovr_load = 1'b0;
    tickq.push_back(c + 14); tickq.push_back(c + 15); tickq.push_back(c + 16);
    wait_to(c + 16);
    enable = 1'b0;
    expect_at(c + 17, ID_OVR, 1);
    wait_to(c + 17);
`endif

    wait_to(cyc + 3);
    stim_done = 1'b1;
  end

endmodule
